sync_fifo_param: RTL and testbench
==================================

# sync_fifo_param

Parametrised synchronous FIFO that generalises the board's 1-bit, 8-deep FIFO to configurable data width and depth. All DEPTH slots are usable; there is no reserved slot. It adds an occupancy count, programmable almost-full/almost-empty thresholds, registered read data with a valid strobe, and sticky overflow/underflow error flags. It sits between the button/switch input logic and the LED output logic, clocked by the slowed display clock temp_clk.

## Interface
- WIDTH, 1: data word width in bits (≥1)
- DEPTH, 8: number of storage words; power of two, ≥2
- AFULL_TH, 6: almost_full asserts when count ≥ AFULL_TH (1..DEPTH)
- AEMPTY_TH, 1: almost_empty asserts when count ≤ AEMPTY_TH (0..DEPTH-1)
- AW (derived, not overridable): clog2(DEPTH)

Ports:
- temp_clk  in  1  clock; all state updates on its rising edge
- rst  in  1  reset, synchronous, active-high
- wr_en  in  1  write request
- wr_data  in  WIDTH  write word
- rd_en  in  1  read request
- clr_err  in  1  synchronous clear of the overflow/underflow sticky flags
- rd_data  out  WIDTH  registered read word; holds its value between reads
- rd_valid  out  1  one-cycle pulse; rd_data was updated this cycle
- count  out  AW+1  number of words stored, 0..DEPTH
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- almost_empty  out  1  count ≤ AEMPTY_TH
- almost_full  out  1  count ≥ AFULL_TH
- overflow  out  1  sticky: a write was rejected
- underflow  out  1  sticky: a read was rejected

## Operation
- Storage: DEPTH×WIDTH memory array. The memory is not reset.
- Pointers: wr_ptr and rd_ptr, each AW+1 bits; the low AW bits address the memory.
- count = wr_ptr − rd_ptr, modulo 2^(AW+1). Wrap-around is natural binary rollover; there is no modulo arithmetic on DEPTH.
- Status flags are combinational decodes of count. count is derived only from registers.
- Write accept: wr_acc = wr_en && (!full || rd_acc).
  - On accept: mem[wr_ptr[AW-1:0]] ← wr_data; wr_ptr ← wr_ptr+1.
- Read accept: rd_acc = rd_en && !empty.
  - On accept: rd_data ← mem[rd_ptr[AW-1:0]]; rd_ptr ← rd_ptr+1; rd_valid ← 1.
  - Otherwise rd_valid ← 0 and rd_data holds.
- Simultaneous read and write:
  - Full with both asserted: both are accepted, count stays DEPTH, no overflow.
  - Empty with both asserted: only the write is accepted, and underflow sets. There is no write-to-read bypass.
  - Any other count: both accepted, count unchanged.
- Error flags:
  - overflow sets when wr_en && !wr_acc.
  - underflow sets when rd_en && !rd_acc.
  - Both are cleared by clr_err or rst.
  - If clr_err and a new error occur in the same cycle, the set wins.
- Reset (any cycle, including mid-transfer): wr_ptr=0, rd_ptr=0, rd_data=0, rd_valid=0, overflow=0, underflow=0. Stored contents are discarded, and requests in the reset cycle are ignored.
- Output values after reset: count=0, empty=1, full=0, almost_empty=1 (AEMPTY_TH≥0), almost_full=0.

## Timing
- Write to status latency is 1 cycle: a write accepted at edge N updates count, empty and almost_* after edge N.
- Read latency is 1 cycle: with rd_en high before edge N, rd_data/rd_valid are valid after edge N. rd_valid is high for exactly one cycle per accepted read.
- Back-to-back reads on consecutive cycles give one word per cycle, with rd_valid held high continuously.
- A word written at edge N is readable by a request sampled at edge N+1 at the earliest.
- Flag outputs have no combinational path from wr_en/rd_en. Only wr_acc/rd_acc are internal combinational terms.
- Throughput is 1 write and 1 read per cycle, sustained.

## Test plan
- Reset, then write 0..7 with WIDTH=4, DEPTH=8 → count steps 1..8, full=1 after the 8th, almost_full first high at count=6. A 9th write sets overflow=1 and count stays 8.
- Read 8 words from full → rd_data = 0,1,…,7 on consecutive cycles, each with rd_valid=1. After the last, empty=1 and almost_empty=1 at count≤1. A 9th read sets underflow=1 and rd_data holds 7.
- Simultaneous rd_en/wr_en at full with wr_data=A → count stays 8, rd_data = oldest word, no overflow. Draining returns A last.
- Simultaneous rd_en/wr_en at empty with wr_data=5 → count=1, underflow=1, rd_valid=0. A read on the next cycle returns 5.
- Run 20 writes/reads interleaved with occupancy kept at 3 → pointers wrap past 2^(AW+1) and the data order is preserved.
- Assert rst with count=5 → the next cycle shows count=0, empty=1, rd_valid=0, flags cleared. Assert clr_err with overflow set → overflow=0 on the next cycle.

Source files
------------

// File: rtl/sync_fifo_param.sv
// Parametrised synchronous FIFO with occupancy count, almost-full/empty thresholds,
// registered read data with a valid strobe, and sticky overflow/underflow flags.
module sync_fifo_param #(
    parameter int unsigned WIDTH     = 1,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned AFULL_TH  = 6,
    parameter int unsigned AEMPTY_TH = 1,
    localparam int unsigned AW       = $clog2(DEPTH)
) (
    input  logic             temp_clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic             clr_err,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic [AW:0]      count,
    output logic             empty,
    output logic             full,
    output logic             almost_empty,
    output logic             almost_full,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [AW:0] DepthCnt = (AW + 1)'(DEPTH);
    localparam logic [AW:0] AfullCnt = (AW + 1)'(AFULL_TH);
    localparam logic [AW:0] AemptyCnt = (AW + 1)'(AEMPTY_TH);
    localparam logic [AW:0] PtrOne = (AW + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             wr_acc, rd_acc;

    // Extra pointer bit distinguishes full from empty, so every slot is usable.
    assign count        = wr_ptr_q - rd_ptr_q;
    assign empty        = (count == '0);
    assign full         = (count == DepthCnt);
    assign almost_empty = (count <= AemptyCnt);
    assign almost_full  = (count >= AfullCnt);

    assign rd_acc = rd_en && !empty;
    assign wr_acc = wr_en && (!full || rd_acc);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (rd_acc) begin
            rd_ptr_d   = rd_ptr_q + PtrOne;
            rd_data_d  = mem[rd_ptr_q[AW-1:0]];
            rd_valid_d = 1'b1;
        end
        if (clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        // A new error in the same cycle as clr_err must not be lost.
        if (wr_en && !wr_acc) begin
            overflow_d = 1'b1;
        end
        if (rd_en && !rd_acc) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge temp_clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge temp_clk) begin
        if (!rst && wr_acc) begin
            mem[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param (WIDTH=4, DEPTH=8): table-driven vectors plus a
// hand-written pointer wrap-around sequence.
module tb_sync_fifo_param;

    logic       temp_clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [3:0] wr_data = '0;
    logic       rd_en = 1'b0;
    logic       clr_err = 1'b0;
    logic [3:0] rd_data;
    logic       rd_valid;
    logic [3:0] count;
    logic       empty, full, almost_empty, almost_full, overflow, underflow;

    int checks = 0;
    int errors = 0;

    sync_fifo_param #(
        .WIDTH    (4),
        .DEPTH    (8),
        .AFULL_TH (6),
        .AEMPTY_TH(1)
    ) dut (
        .temp_clk    (temp_clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .clr_err     (clr_err),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .almost_empty(almost_empty),
        .almost_full (almost_full),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 temp_clk = ~temp_clk;

    typedef struct {
        logic       rst, wr_en, rd_en, clr_err;
        logic [3:0] wr_data;
        logic [3:0] e_count;
        logic       e_valid;
        logic [3:0] e_data;
        logic       e_full, e_empty, e_ae, e_af, e_ovf, e_unf;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic w, input logic rd, input logic c,
                       input int d, input int cnt, input logic v, input int q,
                       input logic ovf, input logic unf);
        vec_t x;
        x.rst = r; x.wr_en = w; x.rd_en = rd; x.clr_err = c; x.wr_data = 4'(d);
        x.e_count = 4'(cnt); x.e_valid = v; x.e_data = 4'(q);
        x.e_full = (cnt == 8); x.e_empty = (cnt == 0);
        x.e_ae = (cnt <= 1); x.e_af = (cnt >= 6);
        x.e_ovf = ovf; x.e_unf = unf;
        vecs.push_back(x);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic w, input logic rd, input logic c,
                        input logic [3:0] d);
        rst = r; wr_en = w; rd_en = rd; clr_err = c; wr_data = d;
        @(posedge temp_clk);
        #1;
    endtask

    initial begin
        // Reset and fill 0..7
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 8; i++) add(0, 1, 0, 0, i - 1, i, 0, 0, 0, 0);
        add(0, 1, 0, 0, 9, 8, 0, 0, 1, 0);                 // write while full
        for (int i = 0; i < 8; i++) add(0, 0, 1, 0, 0, 7 - i, 1, i, 1, 0);
        add(0, 0, 1, 0, 0, 0, 0, 7, 1, 1);                 // read while empty
        add(0, 0, 1, 1, 0, 0, 0, 7, 0, 1);                 // new underflow beats clr_err
        add(0, 0, 0, 1, 0, 0, 0, 7, 0, 0);
        for (int i = 0; i < 8; i++) add(0, 1, 0, 0, 8 + i, i + 1, 0, 7, 0, 0);
        add(0, 1, 1, 0, 10, 8, 1, 8, 0, 0);                // rd+wr at full
        for (int i = 0; i < 8; i++) add(0, 0, 1, 0, 0, 7 - i, 1, (i < 7) ? 9 + i : 10, 0, 0);
        add(0, 1, 1, 0, 5, 1, 0, 10, 0, 1);                // rd+wr at empty: no bypass
        add(0, 0, 1, 0, 0, 0, 1, 5, 0, 1);
        add(0, 0, 0, 1, 0, 0, 0, 5, 0, 0);
        for (int i = 1; i <= 6; i++) add(0, 1, 0, 0, i, i, 0, 5, 0, 0);
        add(0, 0, 1, 0, 0, 5, 1, 1, 0, 0);
        add(1, 1, 1, 0, 3, 0, 0, 0, 0, 0);                 // reset mid-transfer
        add(0, 0, 1, 0, 0, 0, 0, 0, 0, 1);                 // contents discarded

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].wr_en, vecs[i].rd_en, vecs[i].clr_err, vecs[i].wr_data);
            chk($sformatf("v%0d count", i), 32'(count), 32'(vecs[i].e_count));
            chk($sformatf("v%0d rd_valid", i), 32'(rd_valid), 32'(vecs[i].e_valid));
            chk($sformatf("v%0d rd_data", i), 32'(rd_data), 32'(vecs[i].e_data));
            chk($sformatf("v%0d full", i), 32'(full), 32'(vecs[i].e_full));
            chk($sformatf("v%0d empty", i), 32'(empty), 32'(vecs[i].e_empty));
            chk($sformatf("v%0d almost_empty", i), 32'(almost_empty), 32'(vecs[i].e_ae));
            chk($sformatf("v%0d almost_full", i), 32'(almost_full), 32'(vecs[i].e_af));
            chk($sformatf("v%0d overflow", i), 32'(overflow), 32'(vecs[i].e_ovf));
            chk($sformatf("v%0d underflow", i), 32'(underflow), 32'(vecs[i].e_unf));
        end

        // Wrap: hold occupancy at 3 while 23 words pass through 4-bit pointers.
        step(0, 0, 0, 1, 4'd0);
        for (int k = 0; k < 3; k++) step(0, 1, 0, 0, 4'(k));
        chk("wrap prefill count", 32'(count), 32'd3);
        for (int k = 0; k < 20; k++) begin
            step(0, 1, 1, 0, 4'(k + 3));
            chk($sformatf("wrap%0d rd_data", k), 32'(rd_data), 32'(k % 16));
            chk($sformatf("wrap%0d rd_valid", k), 32'(rd_valid), 32'd1);
            chk($sformatf("wrap%0d count", k), 32'(count), 32'd3);
        end
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 1, 0, 4'd0);
            chk($sformatf("wrap drain%0d rd_data", k), 32'(rd_data), 32'((20 + k) % 16));
        end
        chk("wrap empty", 32'(empty), 32'd1);
        chk("wrap overflow", 32'(overflow), 32'd0);
        chk("wrap underflow", 32'(underflow), 32'd0);

        step(0, 0, 0, 0, 4'd0);
        chk("idle rd_valid", 32'(rd_valid), 32'd0);
        chk("idle rd_data hold", 32'(rd_data), 32'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
